// File: rtl/pipe_stage_pkg.sv
// Shared types for the MINA2000 inter-stage pipeline registers.
// pipe_stage uses pipe_state_t when built with MINA_PIPE_SKID_EN.
// The *_PARAMS_W constants size the pipe_stage instance at each boundary.
package pipe_stage_pkg;

  // Occupancy of a skid-buffered stage
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_FULL  = 2'd1,
    PIPE_SKID  = 2'd2
  } pipe_state_t;

  // IF/ID boundary payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_params_t;

  // ID/EX boundary payload
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } ex_params_t;

  // EX/MEM boundary payload
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } mem_params_t;

  // MEM/WB boundary payload
  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } wb_params_t;

  localparam int unsigned IF_PARAMS_W  = $bits(if_params_t);
  localparam int unsigned EX_PARAMS_W  = $bits(ex_params_t);
  localparam int unsigned MEM_PARAMS_W = $bits(mem_params_t);
  localparam int unsigned WB_PARAMS_W  = $bits(wb_params_t);

  // A stage presents data downstream whenever its main entry is occupied
  function automatic logic pipe_state_valid(pipe_state_t state);
    return state != PIPE_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Skid register plus its valid flag for pipe_stage.
// It is instantiated only when MINA_PIPE_SKID_EN is defined.
// It catches the one payload accepted while downstream was stalled.
module pipe_skid_buf
  import pipe_stage_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] load_data,
  output logic             skid_valid,
  output logic [WIDTH-1:0] skid_data
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Capture on load, release on unload; reset and flush empty the entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      if (CLEAR_ON_FLUSH) data_q <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (unload) begin
      valid_q <= 1'b0;
    end
  end

  assign skid_valid = valid_q;
  assign skid_data  = data_q;

endmodule

// File: rtl/pipe_stage.sv
// Generic valid/ready pipeline register for the MINA2000 stage boundaries.
// MINA_PIPE_SKID_EN adds a skid entry so that in_ready comes from a flop.
// Without the macro, in_ready is combinational from out_ready.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned      WIDTH          = 32,
  parameter bit               CLEAR_ON_FLUSH = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

`ifdef MINA_PIPE_SKID_EN

  pipe_state_t      state_q;
  logic [WIDTH-1:0] data_q;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_load;
  logic             skid_unload;
  logic             in_xfer;

  assign out_valid = pipe_state_valid(state_q);
  assign out_data  = data_q;
  assign in_ready  = !skid_valid;
  assign in_xfer   = in_valid && in_ready;

  // An input that arrives while main is held goes to the skid entry
  assign skid_load   = (state_q == PIPE_FULL) && in_xfer && !out_ready;
  assign skid_unload = (state_q == PIPE_SKID) && out_ready;

  pipe_skid_buf #(
    .WIDTH          (WIDTH),
    .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .load       (skid_load),
    .unload     (skid_unload),
    .load_data  (in_data),
    .skid_valid (skid_valid),
    .skid_data  (skid_data)
  );

  // Occupancy FSM and main payload register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PIPE_EMPTY;
      data_q  <= RESET_VALUE;
    end else if (flush) begin
      state_q <= PIPE_EMPTY;
      if (CLEAR_ON_FLUSH) data_q <= '0;
    end else begin
      unique case (state_q)
        PIPE_EMPTY: begin
          if (in_xfer) begin
            state_q <= PIPE_FULL;
            data_q  <= in_data;
          end
        end
        PIPE_FULL: begin
          if (in_xfer && out_ready) begin
            data_q <= in_data;
          end else if (in_xfer) begin
            state_q <= PIPE_SKID;
          end else if (out_ready) begin
            state_q <= PIPE_EMPTY;
          end
        end
        PIPE_SKID: begin
          if (out_ready) begin
            state_q <= PIPE_FULL;
            data_q  <= skid_data;
          end
        end
        default: state_q <= PIPE_EMPTY;
      endcase
    end
  end

`else

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_ready  = !valid_q || out_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Single entry: a new input replaces the departing one in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VALUE;
    end else if (flush) begin
      valid_q <= 1'b0;
      if (CLEAR_ON_FLUSH) data_q <= '0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage, with or without MINA_PIPE_SKID_EN.
// The model is a FIFO queue. It holds one entry, or two with the skid.
module tb_pipe_stage;

  localparam int unsigned      W       = 32;
  localparam logic [W-1:0]     RST_VAL = 32'h0BAD_F00D;
`ifdef MINA_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] shown = RST_VAL;
  bit           chk_en = 1'b0;
  bit           last_acc = 1'b0;

  always #5 clk = ~clk;

  pipe_stage #(
    .WIDTH          (W),
    .CLEAR_ON_FLUSH (1'b1),
    .RESET_VALUE    (RST_VAL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Space is left when the queue is below capacity, or when the head leaves this cycle
  function automatic bit exp_in_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update at each edge, from the inputs only
  always @(posedge clk) begin
    bit acc;
    bit rdy;
    rdy = exp_in_ready();
    acc = 1'b0;
    if (!rst_n) begin
      q.delete();
      shown = RST_VAL;
    end else if (flush) begin
      q.delete();
      shown = '0;
    end else begin
      acc = in_valid && rdy;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(in_data);
      if (q.size() > 0) shown = q[0];
    end
    last_acc = acc;
    chk_en = 1'b1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", W'(in_ready), W'(exp_in_ready()));
      check("out_valid", W'(out_valid), W'(q.size() > 0));
      check("out_data", out_data, shown);
    end
  end

  initial begin
    bit hold;

    // Reset held three edges with a live input
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin rst_n = 1'b1; in_valid = 1'b0; end
      @(negedge clk);
      check("rst_out_valid", W'(out_valid), '0);
      check("rst_out_data", out_data, RST_VAL);
    end
    tick();
    @(negedge clk);
    check("post_rst_in_ready", W'(in_ready), W'(1));

    // Streaming
    tick(); in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b1;
    tick(); in_data = 32'h2;
    @(negedge clk); check("stream_1", out_data, 32'h1); check("stream_v1", W'(out_valid), W'(1));
    tick(); in_data = 32'h3;
    @(negedge clk); check("stream_2", out_data, 32'h2);
    tick(); in_valid = 1'b0;
    @(negedge clk); check("stream_3", out_data, 32'h3); check("stream_v3", W'(out_valid), W'(1));
    tick();
    @(negedge clk); check("stream_end", W'(out_valid), '0);

    // Stall with 0xB offered behind 0xA
    tick(); in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
    tick(); in_data = 32'hB;
    @(negedge clk); check("stall_a0", out_data, 32'hA);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (SKID) in_valid = 1'b0;
      @(negedge clk);
      check("stall_a", out_data, 32'hA);
      check("stall_v", W'(out_valid), W'(1));
      check("stall_in_ready", W'(in_ready), '0);
    end
    tick(); out_ready = 1'b1;
    @(negedge clk); check("rel_a", out_data, 32'hA); check("rel_in_ready", W'(in_ready), W'(!SKID));
    tick(); in_valid = 1'b0;
    @(negedge clk); check("rel_b", out_data, 32'hB); check("rel_bv", W'(out_valid), W'(1));
    tick();
    @(negedge clk); check("rel_empty", W'(out_valid), '0);

    // Flush with a stalled entry (and skid entry when present); 0xC must vanish
    tick(); in_valid = 1'b1; in_data = 32'hA; out_ready = 1'b0;
    tick(); in_data = 32'hB;
    tick(); flush = 1'b1; in_data = 32'hC; out_ready = !SKID;
    @(negedge clk);
    if (SKID) check("skid_full_in_ready", W'(in_ready), '0);
    tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("flush_valid", W'(out_valid), '0);
    check("flush_in_ready", W'(in_ready), W'(1));
    check("flush_data", out_data, '0);
    tick(); out_ready = 1'b1;
    tick();
    @(negedge clk); check("flush_no_c", W'(out_valid), '0);

    // Reset during a stall drops the entry
    tick(); in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    tick(); in_valid = 1'b0; rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", W'(out_valid), '0);
    check("midrst_data", out_data, RST_VAL);

    // Idle hold
    tick(); in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_data", out_data, 32'h55);
      check("idle_valid", W'(out_valid), W'(1));
      tick();
    end
    out_ready = 1'b1;
    tick();

    // Random traffic; a refused input is held stable until taken
    for (int n = 0; n < 10000; n++) begin
      tick();
      hold = in_valid && !last_acc && rst_n && !flush;
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 9) == 0;
      rst_n     = $urandom_range(0, 199) != 0;
    end
    tick(); flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
    tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
